// File: rtl/permutation_output_buffer_pkg.sv
// Shared definitions for the permutation output buffer: bot geometry,
// FIFO entry layout and the series bot counter.
package permutation_output_buffer_pkg;

    localparam int unsigned BOT_WIDTH            = 128;
    localparam int unsigned PERMUTATIONS_PER_BOT = 42;   // 7 x 6 permutations per series
    localparam int unsigned SERIES_COUNT_WIDTH   = 6;

    // Entry field offsets: {seriesEnd, botValid, bot}
    localparam int unsigned ENTRY_BOT_LSB        = 0;
    localparam int unsigned ENTRY_BOT_VALID_BIT  = BOT_WIDTH;
    localparam int unsigned ENTRY_SERIES_END_BIT = BOT_WIDTH + 1;
    localparam int unsigned ENTRY_WIDTH          = BOT_WIDTH + 2;

    typedef struct packed {
        logic                 seriesEnd;
        logic                 botValid;
        logic [BOT_WIDTH-1:0] bot;
    } botEntry_t;

    typedef logic [SERIES_COUNT_WIDTH-1:0] seriesCount_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic seriesCount_t satIncrement(input seriesCount_t value);
        return (value == '1) ? value : value + SERIES_COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/permutation_output_buffer_if.sv
// Stream bundle between the permutator slot, the output buffer and the
// counting pipeline.
//   botIn/botInValid/botSeriesFinishedIn : generator -> buffer
//   slowDown                             : buffer -> generator backpressure
//   botOut/botOutValid/seriesEndOut      : head entry fields, buffer -> consumer
//   outValid/outReady                    : head handshake
// master = generator/consumer side, slave = buffer side.
interface permutation_output_buffer_if;
    import permutation_output_buffer_pkg::*;

    logic [BOT_WIDTH-1:0] botIn;
    logic                 botInValid;
    logic                 botSeriesFinishedIn;
    logic                 slowDown;
    logic [BOT_WIDTH-1:0] botOut;
    logic                 botOutValid;
    logic                 seriesEndOut;
    logic                 outValid;
    logic                 outReady;

    modport master (
        output botIn, botInValid, botSeriesFinishedIn, outReady,
        input  slowDown, botOut, botOutValid, seriesEndOut, outValid
    );

    modport slave (
        input  botIn, botInValid, botSeriesFinishedIn, outReady,
        output slowDown, botOut, botOutValid, seriesEndOut, outValid
    );

endinterface

// File: rtl/bot_entry_fifo_mem.sv
// Simple dual-port entry array for the output FIFO: one synchronous write
// port and a combinational read port at the read pointer. Not reset.
//   clk      : clock
//   wrEn     : write wrData to wrAddr at the clock edge
//   wrAddr   : write address
//   wrData   : entry to store
//   rdAddr   : read address
//   rdData_c : entry at rdAddr (combinational)
module bot_entry_fifo_mem
    import permutation_output_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 7
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [DEPTH_LOG2-1:0] wrAddr,
    input  botEntry_t             wrData,
    input  logic [DEPTH_LOG2-1:0] rdAddr,
    output botEntry_t             rdData_c
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    botEntry_t mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Read port, no output register so the head falls through
    assign rdData_c = mem[rdAddr];

endmodule

// File: rtl/permutation_output_buffer.sv
// Output buffer for one permutator slot. Captures bots and series-end
// pulses into a first-word-fall-through FIFO, presents them to the counting
// pipeline over valid/ready, throttles the generator via slowDown and checks
// that each completed series carried exactly PERMUTATIONS_PER_BOT bots.
//   clk, rst         : clock, synchronous active-high reset
//   bus              : stream bundle (slave side)
//   seriesDone       : one-cycle pulse when a series end is accepted
//   seriesBotCount   : bots in the series just ended, valid with seriesDone
//   seriesCountError : sticky, a non-empty series had the wrong bot count
//   overflowError    : sticky, an entry was dropped on a full FIFO
module permutation_output_buffer
    import permutation_output_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2         = 7,
    parameter int unsigned SLOWDOWN_THRESHOLD = 72
) (
    input  logic                          clk,
    input  logic                          rst,
    permutation_output_buffer_if.slave    bus,
    output logic                          seriesDone,
    output logic [SERIES_COUNT_WIDTH-1:0] seriesBotCount,
    output logic                          seriesCountError,
    output logic                          overflowError
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned OCC_WIDTH = DEPTH_LOG2 + 1;

    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [OCC_WIDTH-1:0]  occupancy;
    logic [OCC_WIDTH-1:0]  occupancyNext;
    seriesCount_t          botCount;
    logic                  slowDownQ;

    logic                  pushReq;
    logic                  popAcc;
    logic                  pushAcc;
    logic                  fifoFull;
    botEntry_t             wrEntry;
    botEntry_t             headEntry;

    // Push/pop decisions; a pop at full frees the slot for a same-cycle push
    always_comb begin
        wrEntry       = '{seriesEnd: bus.botSeriesFinishedIn,
                          botValid:  bus.botInValid,
                          bot:       bus.botIn};
        pushReq       = bus.botInValid || bus.botSeriesFinishedIn;
        popAcc        = (occupancy != '0) && bus.outReady;
        fifoFull      = (occupancy == OCC_WIDTH'(DEPTH));
        pushAcc       = pushReq && (!fifoFull || popAcc);
        occupancyNext = occupancy + OCC_WIDTH'(pushAcc) - OCC_WIDTH'(popAcc);
    end

    bot_entry_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk      (clk),
        .wrEn     (pushAcc && !rst),
        .wrAddr   (wrPtr),
        .wrData   (wrEntry),
        .rdAddr   (rdPtr),
        .rdData_c (headEntry)
    );

    assign bus.botOut       = headEntry.bot;
    assign bus.botOutValid  = headEntry.botValid;
    assign bus.seriesEndOut = headEntry.seriesEnd;
    assign bus.outValid     = (occupancy != '0);
    assign bus.slowDown     = slowDownQ;

    // Pointers, occupancy, backpressure, series accounting and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr            <= '0;
            rdPtr            <= '0;
            occupancy        <= '0;
            botCount         <= '0;
            slowDownQ        <= 1'b0;
            seriesDone       <= 1'b0;
            seriesBotCount   <= '0;
            seriesCountError <= 1'b0;
            overflowError    <= 1'b0;
        end else begin
            if (pushAcc) begin
                wrPtr <= wrPtr + DEPTH_LOG2'(1);
            end
            if (popAcc) begin
                rdPtr <= rdPtr + DEPTH_LOG2'(1);
            end
            occupancy  <= occupancyNext;
            slowDownQ  <= (occupancyNext >= OCC_WIDTH'(SLOWDOWN_THRESHOLD));
            seriesDone <= 1'b0;

            if (pushReq && !pushAcc) begin
                overflowError <= 1'b1;
            end

            // A series end closes the old series before this entry's bot,
            // so the reported count excludes it and the new count starts with it
            if (pushAcc) begin
                if (bus.botSeriesFinishedIn) begin
                    seriesDone     <= 1'b1;
                    seriesBotCount <= botCount;
                    if ((botCount != '0) &&
                        (botCount != SERIES_COUNT_WIDTH'(PERMUTATIONS_PER_BOT))) begin
                        seriesCountError <= 1'b1;
                    end
                    botCount <= SERIES_COUNT_WIDTH'(bus.botInValid);
                end else if (bus.botInValid) begin
                    botCount <= satIncrement(botCount);
                end
            end
        end
    end

endmodule
